// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD requester and its engine link.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;
  localparam int DONE_HOLD = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/gcd_requester_if.sv
// Request, engine and response signals of the GCD requester.
interface gcd_requester_if
  #(parameter int WIDTH = gcd_pkg::GCD_WIDTH);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             eng_start;
  logic [WIDTH-1:0] eng_a;
  logic [WIDTH-1:0] eng_b;
  logic             eng_done;
  logic [WIDTH-1:0] eng_gcd;
  logic             eng_rst_n;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_gcd;
  logic             res_err;

  modport master (
    input  req_valid, req_a, req_b,
    input  eng_done, eng_gcd, res_ready,
    output req_ready, eng_start, eng_a, eng_b,
    output eng_rst_n, res_valid, res_gcd,
    output res_err
  );

  modport slave (
    output req_valid, req_a, req_b,
    output eng_done, eng_gcd, res_ready,
    input  req_ready, eng_start, eng_a, eng_b,
    input  eng_rst_n, res_valid, res_gcd,
    input  res_err
  );

endinterface

// File: rtl/gcd_req_watchdog.sv
// BUSY-time watchdog: cleared on load, counts while enabled,
// flags expiry once the count reaches TIMEOUT.
module gcd_req_watchdog #(
  parameter int TIMEOUT = 70000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/gcd_requester.sv
// Initiator for the start/done GCD engine; zero operands bypass it.
// Optional BUSY watchdog: define GCD_REQ_TIMEOUT_EN.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = 70000
) (
  input logic           clk,
  input logic           rst_n,
  gcd_requester_if.master bus
);

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] res_gcd_q;
  logic             req_ready_q;
  logic             eng_start_q;
  logic             res_valid_q;
  logic             res_err_q;
  logic             eng_rst_n_q;
  logic             expire;
  logic             zero_op;

  assign zero_op = (bus.req_a == '0)
                || (bus.req_b == '0);

`ifdef GCD_REQ_TIMEOUT_EN
  logic wd_load;
  logic wd_en;

  assign wd_load = (state_q == S_ISSUE);
  assign wd_en   = (state_q == S_BUSY);

  gcd_req_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (wd_load),
    .en_i     (wd_en),
    .expire_o (expire)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire = 1'b0;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_a     = op_a_q;
  assign bus.eng_b     = op_b_q;
  assign bus.eng_rst_n = eng_rst_n_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_gcd   = res_gcd_q;
  assign bus.res_err   = res_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_gcd_q   <= '0;
      req_ready_q <= 1'b1;
      eng_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      eng_rst_n_q <= 1'b1;
    end else begin
      eng_start_q <= 1'b0;
      eng_rst_n_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_a_q      <= bus.req_a;
            op_b_q      <= bus.req_b;
            req_ready_q <= 1'b0;
            res_err_q   <= 1'b0;
            // The subtractive engine never ends on a zero operand
            if (zero_op) begin
              res_gcd_q   <= bus.req_a | bus.req_b;
              res_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              eng_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (bus.eng_done) begin
            res_gcd_q <= bus.eng_gcd;
            state_q   <= S_DRAIN;
          end else if (expire) begin
            eng_rst_n_q <= 1'b0;
            res_err_q   <= 1'b1;
            res_gcd_q   <= '0;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_DRAIN: begin
          if (!bus.eng_done) begin
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
